dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data memory (word-addressed, synchronous read, one-cycle read latency) between the MIPS CPU load/store path and a host port used by the sensor/loader to deposit measurements and read results. It sits between the requesters and the data memory, sequencing each access through a fixed grant/access/response pipeline so that neither requester drives the memory directly. Arbitration is fixed-priority or round-robin depending on build configuration.

---
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported, synchronous-read data memory
// between the CPU load/store path and the host (sensor/loader) port.
// Every access runs through ACCESS (grant + memory strobe) and RESP
// (response with the memory's registered read data), so neither requester
// ever drives the memory directly.
// Build option: define ARB_ROUND_ROBIN_EN to break ties round-robin;
// left undefined, the CPU wins every tie (fixed priority).
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    // CPU requester
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    // host requester
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    // data memory port
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic              we_q;      // latched direction of the transaction in flight
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              any_req;
    logic              pick_host; // winner if this edge is an arbitration edge
    logic              arb_edge;

    assign any_req  = cpu_req | host_req;
    assign arb_edge = (state != ACCESS);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_host; // 1: host was granted most recently

    // Round-robin winner: on a tie, favour whoever was not granted last
    // NOTE: one unconditional assignment covers every path, so no latch can be inferred.
    always_comb pick_host = host_req & (~cpu_req | ~last_host);

    // Pointer follows every grant, contested or not; reset leaves CPU as "last"
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_host <= 1'b0;
        else if (arb_edge && any_req)
            last_host <= pick_host;
    end
`else
    // Fixed-priority winner: host only when the CPU is not asking
    // NOTE: one unconditional assignment covers every path, so no latch can be inferred.
    always_comb pick_host = host_req & ~cpu_req;
`endif

    // Transaction FSM; every control output is a register so it is glitch-free
    // and the async reset clears mem_we the instant reset_n falls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cpu_gnt     <= 1'b0;
            host_gnt    <= 1'b0;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            mem_we      <= 1'b0;
            busy        <= 1'b0;
            owner       <= 1'b0;
            // NOTE: the latched request is reset because it is visible on mem_addr/mem_wdata.
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments only; pulses default low and are raised below.
            cpu_gnt     <= 1'b0;
            host_gnt    <= 1'b0;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            mem_we      <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (any_req) begin
                        state    <= ACCESS;
                        owner    <= pick_host;
                        we_q     <= pick_host ? host_we    : cpu_we;
                        addr_q   <= pick_host ? host_addr  : cpu_addr;
                        wdata_q  <= pick_host ? host_wdata : cpu_wdata;
                        mem_we   <= pick_host ? host_we    : cpu_we;
                        cpu_gnt  <= ~pick_host;
                        host_gnt <= pick_host;
                        busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ACCESS: begin
                    state       <= RESP;
                    cpu_rvalid  <= ~owner;
                    host_rvalid <= owner;
                    busy        <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Memory port shows the last latched request; strobe is mem_we above
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Read data only exists in RESP (memory registers it on the ACCESS->RESP edge),
    // so it is steered through here; stores and idle cycles return 0
    assign cpu_rdata  = (cpu_rvalid  && !we_q) ? mem_rdata : '0;
    assign host_rdata = (host_rvalid && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. Holds a small
// synchronous-read memory, a table of directed vectors, hand-written corner
// sequences, and a transaction-level reference model used for all cycles.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        cpu_req, cpu_we, host_req, host_we;
    logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
    logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
    logic [31:0] cpu_rdata, host_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        owner, busy;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 16-word data memory, word index from addr[5:2], one-cycle read latency
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[5:2]];
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction schedule) ----------------
    typedef struct {
        logic        cgnt, hgnt, crv, hrv, we, busy;
        logic [31:0] crd, hrd;
    } slot_t;

    slot_t       cur_s, nxt_s;      // expected pulses for this cycle / the next
    int          free_cnt;          // edges still to pass before the next arbitration
    logic        own_m;
    logic [31:0] maddr_m, mwd_m;
    logic [31:0] ref_mem [16];
    bit          pw_v;              // store committed at the end of its ACCESS cycle
    logic [3:0]  pw_i;
    logic [31:0] pw_d;
`ifdef ARB_ROUND_ROBIN_EN
    bit          last_host_m;
`endif

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic model_reset();
        cur_s    = empty_slot();
        nxt_s    = empty_slot();
        free_cnt = 0;
        own_m    = 1'b0;
        maddr_m  = '0;
        mwd_m    = '0;
        pw_v     = 0;
`ifdef ARB_ROUND_ROBIN_EN
        last_host_m = 0;
`endif
    endtask

    task automatic model_edge();
        bit          h, we;
        logic [31:0] a, d;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (pw_v) ref_mem[pw_i] = pw_d;
        pw_v  = 0;
        cur_s = nxt_s;
        nxt_s = empty_slot();
        if (free_cnt > 0) begin
            free_cnt--;
        end else if (cpu_req || host_req) begin
            if (cpu_req && host_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                h = !last_host_m;
`else
                h = 0;
`endif
            end else begin
                h = host_req;
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_host_m = h;
`endif
            we = h ? host_we    : cpu_we;
            a  = h ? host_addr  : cpu_addr;
            d  = h ? host_wdata : cpu_wdata;
            own_m   = h;
            maddr_m = a;
            mwd_m   = d;
            cur_s.cgnt = !h;
            cur_s.hgnt = h;
            cur_s.we   = we;
            cur_s.busy = 1'b1;
            nxt_s.busy = 1'b1;
            nxt_s.crv  = !h;
            nxt_s.hrv  = h;
            if (we) begin
                pw_v = 1;
                pw_i = a[5:2];
                pw_d = d;
            end else if (h) begin
                nxt_s.hrd = ref_mem[a[5:2]];
            end else begin
                nxt_s.crd = ref_mem[a[5:2]];
            end
            free_cnt = 1;
        end
    endtask

    task automatic check_outputs();
        check1 ("cpu_gnt",     cpu_gnt,     cur_s.cgnt);
        check1 ("host_gnt",    host_gnt,    cur_s.hgnt);
        check1 ("cpu_rvalid",  cpu_rvalid,  cur_s.crv);
        check1 ("host_rvalid", host_rvalid, cur_s.hrv);
        check32("cpu_rdata",   cpu_rdata,   cur_s.crd);
        check32("host_rdata",  host_rdata,  cur_s.hrd);
        check1 ("mem_we",      mem_we,      cur_s.we);
        check1 ("busy",        busy,        cur_s.busy);
        check1 ("owner",       owner,       own_m);
        check32("mem_addr",    mem_addr,    maddr_m);
        check32("mem_wdata",   mem_wdata,   mwd_m);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // ---------------- requester stimulus (protocol-compliant) ----------------
    bit c_pend, h_pend, c_seen, h_seen;

    task automatic drive_requests(input bit rand_fields, input int unsigned pct);
        if (c_seen) c_pend = 0;
        c_seen = cur_s.cgnt;
        if (!c_pend && $urandom_range(99) < pct) begin
            c_pend = 1;
            if (rand_fields) begin
                cpu_we    = 1'($urandom_range(1));
                cpu_addr  = $urandom();
                cpu_wdata = $urandom();
            end
        end
        cpu_req = c_pend;
        if (h_seen) h_pend = 0;
        h_seen = cur_s.hgnt;
        if (!h_pend && $urandom_range(99) < pct) begin
            h_pend = 1;
            if (rand_fields) begin
                host_we    = 1'($urandom_range(1));
                host_addr  = $urandom();
                host_wdata = $urandom();
            end
        end
        host_req = h_pend;
    endtask

    task automatic go_quiet(input int n);
        c_pend = 0; h_pend = 0; c_seen = 0; h_seen = 0;
        cpu_req = 1'b0; host_req = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        c_req, c_we;
        logic [31:0] c_addr, c_wd;
        logic        h_req, h_we;
        logic [31:0] h_addr, h_wd;
        logic        e_cgnt, e_hgnt, e_crv;
        logic [31:0] e_crd;
        logic        e_hrv;
        logic [31:0] e_hrd;
        logic        e_we;
        logic [31:0] e_addr, e_wd;
        logic        e_busy, e_own;
    } vec_t;

    initial begin
        vec_t tbl [5];
        int   gnt_seq [$];
        int   gnt_cyc [$];
        int   we_cnt, k;
        bit   upd;

        for (int i = 0; i < 16; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        model_reset();

        // host store 0x26 -> word 0, then CPU load of word 0
        tbl[0] = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b1, 32'h0, 32'h26,
                   1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 32'h0, 32'h26,       1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b1, 32'h0, 32'h26,
                   1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0, 1'b0, 32'h0, 32'h26,       1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0,
                   1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0,
                   1'b0, 1'b0, 1'b1, 32'h26, 1'b0, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0,
                   1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};

        // ---- reset with both requesters asking: nothing may be granted ----
        reset_n  = 1'b0;
        cpu_req  = 1'b1; cpu_we  = 1'b0; cpu_addr  = 32'h4; cpu_wdata  = 32'h0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'h8; host_wdata = 32'h0;
        c_pend = 1; h_pend = 1; c_seen = 0; h_seen = 0;
        for (int i = 0; i < 3; i++) step();
        check1 ("rst.cpu_gnt",   cpu_gnt,     1'b0);
        check1 ("rst.host_gnt",  host_gnt,    1'b0);
        check1 ("rst.rvalid",    cpu_rvalid | host_rvalid, 1'b0);
        check1 ("rst.mem_we",    mem_we,      1'b0);
        check1 ("rst.busy",      busy,        1'b0);
        check1 ("rst.owner",     owner,       1'b0);
        check32("rst.cpu_rdata", cpu_rdata,   32'h0);
        check32("rst.host_rdata",host_rdata,  32'h0);
        check32("rst.mem_addr",  mem_addr,    32'h0);
        check32("rst.mem_wdata", mem_wdata,   32'h0);

        // ---- release; both loads held high: tie-breaking sequence ----
        reset_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step();
            if (t == 0) check1("first_gnt", cpu_gnt | host_gnt, 1'b1);
            if (cpu_gnt)  gnt_seq.push_back(0);
            if (host_gnt) gnt_seq.push_back(1);
            drive_requests(1'b0, 100);
        end
        check32("tie.n_grants", 32'(gnt_seq.size()), 32'd5);
        for (int i = 0; i < gnt_seq.size() && i < 5; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            check32("tie.winner", 32'(gnt_seq[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
`else
            check32("tie.winner", 32'(gnt_seq[i]), 32'd0);
`endif
        end
        go_quiet(4);

        // ---- table: host store then CPU load of the same word ----
        for (int i = 0; i < 5; i++) begin
            cpu_req  = tbl[i].c_req;  cpu_we  = tbl[i].c_we;
            cpu_addr = tbl[i].c_addr; cpu_wdata = tbl[i].c_wd;
            host_req = tbl[i].h_req;  host_we = tbl[i].h_we;
            host_addr = tbl[i].h_addr; host_wdata = tbl[i].h_wd;
            step();
            check1 ("tbl.cpu_gnt",     cpu_gnt,     tbl[i].e_cgnt);
            check1 ("tbl.host_gnt",    host_gnt,    tbl[i].e_hgnt);
            check1 ("tbl.cpu_rvalid",  cpu_rvalid,  tbl[i].e_crv);
            check32("tbl.cpu_rdata",   cpu_rdata,   tbl[i].e_crd);
            check1 ("tbl.host_rvalid", host_rvalid, tbl[i].e_hrv);
            check32("tbl.host_rdata",  host_rdata,  tbl[i].e_hrd);
            check1 ("tbl.mem_we",      mem_we,      tbl[i].e_we);
            check32("tbl.mem_addr",    mem_addr,    tbl[i].e_addr);
            check32("tbl.mem_wdata",   mem_wdata,   tbl[i].e_wd);
            check1 ("tbl.busy",        busy,        tbl[i].e_busy);
            check1 ("tbl.owner",       owner,       tbl[i].e_own);
        end
        go_quiet(2);

        // ---- throughput: four back-to-back CPU stores to words 0..3 ----
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'h100;
        k = 0; upd = 0; we_cnt = 0;
        for (int t = 0; t < 12; t++) begin
            step();
            if (upd) begin
                upd = 0;
                if (k < 4) begin
                    cpu_addr  = 32'(4 * k);
                    cpu_wdata = 32'h100 + 32'(k);
                end else begin
                    cpu_req = 1'b0;
                end
            end
            if (mem_we) we_cnt++;
            if (cpu_gnt) begin
                gnt_cyc.push_back(t);
                k++;
                upd = 1;
            end
        end
        check32("thru.n_grants", 32'(gnt_cyc.size()), 32'd4);
        check32("thru.mem_we_cycles", 32'(we_cnt), 32'd4);
        for (int i = 1; i < gnt_cyc.size(); i++)
            check32("thru.gnt_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd2);
        for (int i = 0; i < 4; i++)
            check32("thru.mem_word", mem[i], 32'h100 + 32'(i));
        go_quiet(2);

        // ---- reset during ACCESS of a host store 0x1 -> 0xC ----
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'hC; host_wdata = 32'h1;
        step();
        check1("rma.host_gnt", host_gnt, 1'b1);
        check1("rma.mem_we_before", mem_we, 1'b1);
        reset_n = 1'b0;
        model_reset();
        #1;
        check1("rma.mem_we_async", mem_we, 1'b0);
        host_req = 1'b0;
        step();
        check1("rma.host_rvalid", host_rvalid, 1'b0);
        step();
        check32("rma.mem_word_c", mem[3], 32'h103);
        reset_n = 1'b1;
        go_quiet(2);

        // ---- randomized traffic against the model ----
        for (int t = 0; t < 600; t++) begin
            drive_requests(1'b1, 40);
            step();
        end
        go_quiet(4);
        for (int i = 0; i < 16; i++)
            check32("final.mem_word", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
